// File: rtl/cpu_controller_hs.sv
// Multicycle CPU control FSM with req/ready memory handshake, wait timeout and trap path.
module cpu_controller_hs #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TRAP_EN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       no_op,
  input  logic       move_to,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       result_src,
  output logic       a3_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] pc_src,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       branch,
  output logic       old_pc_write,
  output logic       mdr_write,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam bit             TO_EN     = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);
  localparam logic [1:0]     CAUSE_ILL = 2'd1;
  localparam logic [1:0]     CAUSE_TMO = 2'd2;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_BRANCH, S_C_ALU, S_C_WB, S_JUMP, S_STORE,
    S_LOAD_EX, S_LOAD_MEM, S_LOAD_WB, S_IMM_EX, S_IMM_WB, S_TRAP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_nxt;
  logic             mem_state_c;
  logic             timeout_c;
  logic             zero_unused;

  // Branch-taken is formed in the datapath; the flag is not needed here.
  assign zero_unused = zero;

  assign mem_state_c = (state == S_IF) || (state == S_STORE) || (state == S_LOAD_MEM);
  assign timeout_c   = TO_EN && (wait_cnt == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IF;
    else      state <= state_nxt;
  end

  // Memory wait counter and sticky trap cause captured on entry to TRAP.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt   <= '0;
      trap_cause <= 2'd0;
    end else begin
      if (mem_state_c && !mem_ready && !timeout_c) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                         wait_cnt <= '0;
      if (state_nxt == S_TRAP) trap_cause <= cause_nxt;
    end
  end

  // Next-state decode; mem_ready takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    cause_nxt = 2'd0;
    case (state)
      S_IF: begin
        if (mem_ready) state_nxt = S_ID;
        else if (timeout_c) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TMO;
        end
      end
      S_ID: begin
        casez (opcode)
          4'b0100: state_nxt = S_BRANCH;
          4'b1000: state_nxt = S_C_ALU;
          4'b0010: state_nxt = S_JUMP;
          4'b0001: state_nxt = S_STORE;
          4'b0000: state_nxt = S_LOAD_EX;
          4'b11??: state_nxt = S_IMM_EX;
          default: begin
            if (TRAP_EN != 0) begin
              state_nxt = S_TRAP;
              cause_nxt = CAUSE_ILL;
            end else begin
              state_nxt = S_IF;
            end
          end
        endcase
      end
      S_C_ALU:   state_nxt = S_C_WB;
      S_LOAD_EX: state_nxt = S_LOAD_MEM;
      S_IMM_EX:  state_nxt = S_IMM_WB;
      S_STORE, S_LOAD_MEM: begin
        if (mem_ready) state_nxt = (state == S_STORE) ? S_IF : S_LOAD_WB;
        else if (timeout_c) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_TMO;
        end
      end
      default: state_nxt = S_IF;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    mem_req      = 1'b0;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    result_src   = 1'b0;
    a3_src       = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    imm_src      = 2'b00;
    pc_src       = 2'b00;
    alu_op       = 3'b000;
    pc_write     = 1'b0;
    branch       = 1'b0;
    old_pc_write = 1'b0;
    mdr_write    = 1'b0;
    trap         = 1'b0;
    if (rst) begin
      case (state)
        S_IF: begin
          mem_req      = 1'b1;
          alu_src_b    = 2'b01;
          ir_write     = mem_ready;
          pc_write     = mem_ready;
          old_pc_write = mem_ready;
        end
        S_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = 3'b100;
          pc_src    = 2'b10;
          branch    = 1'b1;
        end
        S_C_ALU: begin
          alu_src_a = 2'b10;
          alu_op    = 3'b100;
        end
        S_C_WB: begin
          a3_src    = move_to;
          reg_write = !no_op;
        end
        S_JUMP: begin
          pc_src   = 2'b01;
          pc_write = 1'b1;
        end
        S_STORE: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 3'b100;
          mem_write = mem_ready;
        end
        S_LOAD_EX: begin
          alu_src_b = 2'b10;
          alu_op    = 3'b100;
        end
        S_LOAD_MEM: begin
          mem_req   = 1'b1;
          adr_src   = 1'b1;
          mdr_write = mem_ready;
        end
        S_LOAD_WB: begin
          result_src = 1'b1;
          reg_write  = 1'b1;
        end
        S_IMM_EX: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
          alu_op    = {1'b0, opcode[1:0]};
        end
        S_IMM_WB: reg_write = 1'b1;
        S_TRAP: begin
          trap     = 1'b1;
          pc_src   = 2'b11;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
